// File: rtl/vending_pkg.sv
// Shared coin and dispenser-state definitions for the change payout path.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package vending_pkg;

    localparam int NUM_COIN = 4;

    // Enum order is denomination priority: index 0 is the largest coin.
    typedef enum logic [1:0] {
        COIN_20 = 2'd0,
        COIN_10 = 2'd1,
        COIN_5  = 2'd2,
        COIN_1  = 2'd3
    } coin_e;

    localparam logic [7:0] COIN_VAL [NUM_COIN] = '{8'd20, 8'd10, 8'd5, 8'd1};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SELECT   = 2'd1,
        WAIT_ACK = 2'd2,
        DONE     = 2'd3
    } disp_state_e;

    // Hopper strobe layout is {c20,c10,c5,c1}.
    function automatic logic [NUM_COIN-1:0] coin_onehot(input coin_e c);
        return 4'b1000 >> c;
    endfunction

endpackage

// File: rtl/coin_inventory.sv
// Per-denomination coin counters with saturating refill, single-coin decrement and empty flags.
// Latency: counts update on the edge after refill/decrement; empty flags follow the registered counts.
// Backpressure: none; the caller gates refill and decrement by dispenser state.
module coin_inventory
    import vending_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int INIT_COUNT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                refill_vld,
    input  coin_e               refill_sel,
    input  logic [CNT_W-1:0]    refill_qty,
    input  logic                dec_vld,
    input  coin_e               dec_sel,
    output logic [NUM_COIN-1:0] empty
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_INIT =
        (INIT_COUNT >= (2**CNT_W - 1)) ? CNT_MAX : CNT_W'(INIT_COUNT);

    logic [CNT_W-1:0] cnt_q [NUM_COIN];
    logic [CNT_W-1:0] cnt_d [NUM_COIN];

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_COIN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (refill_vld && refill_sel == coin_e'(2'(i)))
                cnt_d[i] = sat_add(cnt_q[i], refill_qty);
            if (dec_vld && dec_sel == coin_e'(2'(i)) && cnt_q[i] != '0)
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
    end

    // Flag order matches the hopper strobe: bit 3 is the 20-unit coin.
    always_comb begin
        empty = '0;
        for (int i = 0; i < NUM_COIN; i++)
            empty[NUM_COIN-1-i] = (cnt_q[i] == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '{default: CNT_INIT};
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/change_dispenser.sv
// Greedy largest-first coin payout FSM driving a one-hot hopper; optional ack timeout via CHANGE_DISP_TIMEOUT_EN.
// Latency: zero amount -> payout_done 2 cycles after req; each coin costs one SELECT cycle plus the ack wait.
// Backpressure: coin_out held until coin_ack; payout_req and refill_valid while busy are dropped.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int AMT_W       = 8,
    parameter int CNT_W       = 4,
    parameter int INIT_COUNT  = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                payout_req,
    input  logic [AMT_W-1:0]    payout_amt,
    input  logic                coin_ack,
    input  logic                refill_valid,
    input  logic [1:0]          refill_sel,
    input  logic [CNT_W-1:0]    refill_qty,
    output logic                busy,
    output logic [NUM_COIN-1:0] coin_out,
    output logic                payout_done,
    output logic [AMT_W-1:0]    shortfall,
    output logic [NUM_COIN-1:0] inv_empty
);

    disp_state_e         state_q, state_d;
    logic [AMT_W-1:0]    remaining_q, remaining_d;
    logic [AMT_W-1:0]    shortfall_q, shortfall_d;
    logic [NUM_COIN-1:0] coin_out_q, coin_out_d;
    logic                done_q, done_d;
    coin_e               cur_q, cur_d;
    logic                dec_vld;
    logic                pick_vld;
    coin_e               pick;

`ifdef CHANGE_DISP_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    coin_inventory #(
        .CNT_W      (CNT_W),
        .INIT_COUNT (INIT_COUNT)
    ) u_inv (
        .clk        (clk),
        .reset_n    (reset_n),
        .refill_vld (refill_valid && state_q == IDLE),
        .refill_sel (coin_e'(refill_sel)),
        .refill_qty (refill_qty),
        .dec_vld    (dec_vld),
        .dec_sel    (cur_q),
        .empty      (inv_empty)
    );

    // Scan smallest to largest so the largest eligible coin wins.
    always_comb begin
        pick_vld = 1'b0;
        pick     = COIN_1;
        for (int i = NUM_COIN - 1; i >= 0; i--) begin
            if (!inv_empty[NUM_COIN-1-i] && 32'(COIN_VAL[i]) <= 32'(remaining_q)) begin
                pick_vld = 1'b1;
                pick     = coin_e'(2'(i));
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        shortfall_d = shortfall_q;
        coin_out_d  = coin_out_q;
        done_d      = 1'b0;
        cur_d       = cur_q;
        dec_vld     = 1'b0;
`ifdef CHANGE_DISP_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (payout_req) begin
                    remaining_d = payout_amt;
                    shortfall_d = '0;
                    state_d     = SELECT;
                end
            end
            SELECT: begin
                if (remaining_q == '0) begin
                    shortfall_d = '0;
                    done_d      = 1'b1;
                    state_d     = DONE;
                end else if (pick_vld) begin
                    coin_out_d  = coin_onehot(pick);
                    cur_d       = pick;
                    state_d     = WAIT_ACK;
`ifdef CHANGE_DISP_TIMEOUT_EN
                    tmo_d       = '0;
`endif
                end else begin
                    shortfall_d = remaining_q;
                    done_d      = 1'b1;
                    state_d     = DONE;
                end
            end
            WAIT_ACK: begin
                if (coin_ack) begin
                    coin_out_d  = '0;
                    remaining_d = remaining_q - AMT_W'(COIN_VAL[cur_q]);
                    dec_vld     = 1'b1;
                    state_d     = SELECT;
                end
`ifdef CHANGE_DISP_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    // Hopper jammed: abandon the coin, inventory untouched, report the rest unpaid.
                    coin_out_d  = '0;
                    shortfall_d = remaining_q;
                    done_d      = 1'b1;
                    state_d     = DONE;
                end else begin
                    tmo_d       = tmo_q + TMO_W'(1);
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            shortfall_q <= '0;
            coin_out_q  <= '0;
            done_q      <= 1'b0;
            cur_q       <= COIN_20;
`ifdef CHANGE_DISP_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            shortfall_q <= shortfall_d;
            coin_out_q  <= coin_out_d;
            done_q      <= done_d;
            cur_q       <= cur_d;
`ifdef CHANGE_DISP_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign busy        = (state_q != IDLE);
    assign coin_out    = coin_out_q;
    assign payout_done = done_q;
    assign shortfall   = shortfall_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: expected coins queued per payout, popped as the hopper strobes appear.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       payout_req;
    logic [7:0] payout_amt;
    logic       coin_ack;
    logic       refill_valid;
    logic [1:0] refill_sel;
    logic [3:0] refill_qty;
    logic       busy;
    logic [3:0] coin_out;
    logic       payout_done;
    logic [7:0] shortfall;
    logic [3:0] inv_empty;

    int errors = 0;
    int checks = 0;
    int lat;
    int ncoins;
    int cyc;
    int done_cnt;

    logic [3:0] coin_q[$];

    localparam logic [3:0] C20 = 4'b1000;
    localparam logic [3:0] C10 = 4'b0100;
    localparam logic [3:0] C5  = 4'b0010;
    localparam logic [3:0] C1  = 4'b0001;

    always #5 clk = ~clk;

    change_dispenser dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .payout_req   (payout_req),
        .payout_amt   (payout_amt),
        .coin_ack     (coin_ack),
        .refill_valid (refill_valid),
        .refill_sel   (refill_sel),
        .refill_qty   (refill_qty),
        .busy         (busy),
        .coin_out     (coin_out),
        .payout_done  (payout_done),
        .shortfall    (shortfall),
        .inv_empty    (inv_empty)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_n(input logic [3:0] c, input int n);
        for (int i = 0; i < n; i++) coin_q.push_back(c);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n      = 1'b0;
        payout_req   = 1'b0;
        coin_ack     = 1'b0;
        refill_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic refill(input logic [1:0] sel, input logic [3:0] qty);
        @(negedge clk);
        refill_valid = 1'b1;
        refill_sel   = sel;
        refill_qty   = qty;
        @(negedge clk);
        refill_valid = 1'b0;
    endtask

    // Issues one payout, acks each coin ack_dly cycles after it appears, and scores coins and shortfall.
    task automatic do_payout(input logic [7:0] amt, input logic [7:0] exp_short, input int ack_dly,
                             input logic rf_en, input logic [1:0] rf_sel, input logic [3:0] rf_qty,
                             output int lat_o, output int ncoins_o);
        int         c;
        int         hold;
        logic       done_seen;
        logic [3:0] cur;
        c = 0; hold = 0; done_seen = 1'b0; cur = '0;
        lat_o = -1; ncoins_o = 0;
        @(negedge clk);
        payout_req   = 1'b1;
        payout_amt   = amt;
        refill_valid = rf_en;
        refill_sel   = rf_sel;
        refill_qty   = rf_qty;
        @(negedge clk);
        payout_req   = 1'b0;
        refill_valid = 1'b0;
        check("busy_after_req", busy, 1);
        while (!done_seen && c < 400) begin
            if (payout_done) begin
                done_seen = 1'b1;
                lat_o     = c + 1;
                check("shortfall", shortfall, exp_short);
                check("coins_left", coin_q.size(), 0);
            end else if (coin_out != 4'b0) begin
                if (hold == 0) begin
                    ncoins_o++;
                    if (coin_q.size() == 0) begin
                        check("extra_coin", coin_out, 0);
                    end else begin
                        cur = coin_q.pop_front();
                        check("coin", coin_out, cur);
                    end
                end else begin
                    check("coin_hold", coin_out, cur);
                end
                if (hold == ack_dly) coin_ack = 1'b1;
                hold++;
            end else begin
                coin_ack = 1'b0;
                hold     = 0;
            end
            if (!done_seen) begin
                @(negedge clk);
                c++;
            end
        end
        coin_ack = 1'b0;
        check("done_seen", done_seen, 1);
        @(negedge clk);
        check("done_pulse_1cyc", payout_done, 0);
        check("idle_after_done", busy, 0);
        check("coin_idle", coin_out, 0);
        coin_q.delete();
    endtask

    initial begin
        reset_n      = 1'b0;
        payout_req   = 1'b0;
        payout_amt   = '0;
        coin_ack     = 1'b0;
        refill_valid = 1'b0;
        refill_sel   = '0;
        refill_qty   = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        check("rst_busy", busy, 0);
        check("rst_coin_out", coin_out, 0);
        check("rst_done", payout_done, 0);
        check("rst_shortfall", shortfall, 0);
        check("rst_inv_empty", inv_empty, 4'b0000);

        // 37 = 20+10+5+1+1 with full inventory.
        coin_q.push_back(C20); coin_q.push_back(C10); coin_q.push_back(C5);
        push_n(C1, 2);
        do_payout(8'd37, 8'd0, 0, 1'b0, 2'd0, 4'd0, lat, ncoins);
        check("n37_coins", ncoins, 5);
        check("n37_inv", inv_empty, 4'b0000);

        // Zero amount: done two cycles after the request, no coin strobe.
        do_payout(8'd0, 8'd0, 0, 1'b0, 2'd0, 4'd0, lat, ncoins);
        check("zero_latency", lat, 2);
        check("zero_coins", ncoins, 0);

        // 100 drains the 20s and half the 10s; 40 then falls back to 5s. Slow ack checks coin hold.
        apply_reset();
        push_n(C20, 4); push_n(C10, 2);
        do_payout(8'd100, 8'd0, 2, 1'b0, 2'd0, 4'd0, lat, ncoins);
        check("n100_inv", inv_empty, 4'b1000);
        push_n(C10, 2); push_n(C5, 4);
        do_payout(8'd40, 8'd0, 0, 1'b0, 2'd0, 4'd0, lat, ncoins);
        check("n40_inv", inv_empty, 4'b1110);

        // 10s refilled 9+9 saturate at 15; 20 refilled in the same cycle as the request.
        refill(2'd1, 4'd9);
        refill(2'd1, 4'd9);
        check("refill_inv", inv_empty, 4'b1010);
        coin_q.push_back(C20); push_n(C1, 4);
        do_payout(8'd25, 8'd1, 0, 1'b1, 2'd0, 4'd1, lat, ncoins);
        check("n25_inv", inv_empty, 4'b1011);
        push_n(C10, 15);
        do_payout(8'd160, 8'd10, 0, 1'b0, 2'd0, 4'd0, lat, ncoins);
        check("sat_coins", ncoins, 15);
        check("n160_inv", inv_empty, 4'b1111);

        // 200 from fresh inventory pays 144 and reports 56 short.
        apply_reset();
        push_n(C20, 4); push_n(C10, 4); push_n(C5, 4); push_n(C1, 4);
        do_payout(8'd200, 8'd56, 1, 1'b0, 2'd0, 4'd0, lat, ncoins);
        check("n200_coins", ncoins, 16);
        check("n200_inv", inv_empty, 4'b1111);

        // Reset while the first coin awaits its ack.
        apply_reset();
        @(negedge clk);
        payout_req = 1'b1;
        payout_amt = 8'd20;
        @(negedge clk);
        payout_req = 1'b0;
        cyc = 0;
        while (coin_out == 4'b0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("coin_before_reset", coin_out, C20);
        reset_n = 1'b0;
        #1;
        check("coin_async_drop", coin_out, 0);
        check("busy_async_drop", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        done_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (payout_done) done_cnt++;
        end
        check("no_done_after_reset", done_cnt, 0);
        check("inv_after_reset", inv_empty, 4'b0000);
        push_n(C20, 4); push_n(C10, 2);
        do_payout(8'd100, 8'd0, 0, 1'b0, 2'd0, 4'd0, lat, ncoins);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
